composite_sync_monitor: RTL

- Downstream consumer of the video generator's luminance/sync pair. Recovers line and frame timing from the sync stream alone.
- Measures line length, classifies sync pulses as horizontal or vertical, and tracks lock.
- Re-emits luminance with pixel/line coordinates, for a capture/compare stage or an on-chip self-check.

---
 rtl/composite_video_pkg.sv | 37 +++
 rtl/composite_sync_monitor_if.sv | 29 ++
 rtl/sync_pulse_classifier.sv | 42 ++++
 rtl/composite_sync_monitor.sv | 111 +++++++++++
 4 files changed

// File: rtl/composite_video_pkg.sv
// Shared composite video timing constants and types.
// Used by both the generator and the sync monitor.
package composite_video_pkg;

    localparam int LINE_CLOCKS = 2032;
    localparam int LINE_TOL    = 8;
    localparam int HSYNC_MIN   = 64;
    localparam int VSYNC_MIN   = 512;
    localparam int LOCK_LINES  = 4;
    localparam int X_WIDTH     = 11;
    localparam int Y_WIDTH     = 9;
    localparam int W_WIDTH     = $clog2(VSYNC_MIN + 1);
    localparam int G_WIDTH     = $clog2(LOCK_LINES + 1);

    typedef logic [X_WIDTH-1:0] x_t;
    typedef logic [X_WIDTH:0]   len_t;
    typedef logic [Y_WIDTH-1:0] y_t;
    typedef logic [W_WIDTH-1:0] w_t;
    typedef logic [G_WIDTH-1:0] g_t;

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } lock_state_e;

    localparam x_t   X_MAX   = '1;
    localparam x_t   X_HALF  = x_t'(LINE_CLOCKS / 2);
    localparam w_t   W_VSYNC = w_t'(VSYNC_MIN);
    localparam w_t   W_HSYNC = w_t'(HSYNC_MIN);
    localparam len_t LEN_LO  = len_t'(LINE_CLOCKS - LINE_TOL);
    localparam len_t LEN_HI  = len_t'(LINE_CLOCKS + LINE_TOL);

    function automatic logic in_tol(input len_t len);
        return (len >= LEN_LO) && (len <= LEN_HI);
    endfunction

endpackage

// File: rtl/composite_sync_monitor_if.sv
// Luminance/sync input pair and recovered timing outputs.
interface composite_sync_monitor_if;
    import composite_video_pkg::*;

    logic luminance;
    logic sync;
    logic line_start;
    logic vsync_pulse;
    x_t   line_length;
    x_t   pixel_x;
    y_t   line_y;
    logic pixel;
    logic pixel_valid;
    logic locked;
    logic lock_error;

    modport master (
        output luminance, sync,
        input  line_start, vsync_pulse, line_length, pixel_x,
        input  line_y, pixel, pixel_valid, locked, lock_error
    );

    modport slave (
        input  luminance, sync,
        output line_start, vsync_pulse, line_length, pixel_x,
        output line_y, pixel, pixel_valid, locked, lock_error
    );

endinterface

// File: rtl/sync_pulse_classifier.sv
// Input registers, sync edge detect and sync-tip width measurement.
module sync_pulse_classifier
    import composite_video_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic luminance,
    input  logic sync,
    output logic lum_r,
    output logic sync_r,
    output logic rise,
    output logic fall,
    output logic is_vsync,
    output logic is_glitch
);

    logic sync_q;
    w_t   width;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lum_r  <= 1'b0;
            sync_r <= 1'b0;
            sync_q <= 1'b0;
            width  <= '0;
        end else begin
            lum_r  <= luminance;
            sync_r <= sync;
            sync_q <= sync_r;
            if (fall)
                width <= '0;
            else if (sync_r && (width != W_VSYNC))
                width <= width + w_t'(1);
        end
    end

    assign rise      = sync_r & ~sync_q;
    assign fall      = ~sync_r & sync_q;
    assign is_vsync  = fall && (width >= W_VSYNC);
    assign is_glitch = fall && (width < W_HSYNC);

endmodule

// File: rtl/composite_sync_monitor.sv
// Recovers line/frame timing and lock state from a composite sync stream.
module composite_sync_monitor
    import composite_video_pkg::*;
(
    input logic                     clock,
    input logic                     reset_n,
    composite_sync_monitor_if.slave vid
);

    logic lum_r, sync_r, rise, fall, is_vsync, is_glitch;

    sync_pulse_classifier u_cls (
        .clock     (clock),
        .reset_n   (reset_n),
        .luminance (vid.luminance),
        .sync      (vid.sync),
        .lum_r     (lum_r),
        .sync_r    (sync_r),
        .rise      (rise),
        .fall      (fall),
        .is_vsync  (is_vsync),
        .is_glitch (is_glitch)
    );

    lock_state_e state, state_nx;
    g_t   good, good_nx;
    x_t   x, len;
    y_t   y;
    len_t x_inc;
    logic x_sat, intol, accept, vs_evt, err_nx;
    logic ls, vs, le, pix, pv;

    assign x_sat  = (x == X_MAX);
    assign x_inc  = len_t'(x) + len_t'(1);
    assign intol  = in_tol(x_inc);
    // A free-running x has seen no line at all, so any rise restarts timing
    assign accept = rise & ((x >= X_HALF) | ((state == UNLOCKED) & x_sat));
    assign vs_evt = fall & ~is_glitch & is_vsync;

    always_comb begin
        state_nx = state;
        good_nx  = good;
        err_nx   = 1'b0;
        unique case (state)
            UNLOCKED: begin
                if (accept) begin
                    if (!intol) begin
                        good_nx = '0;
                    end else if (good == g_t'(LOCK_LINES - 1)) begin
                        state_nx = LOCKED;
                        good_nx  = '0;
                    end else begin
                        good_nx = good + g_t'(1);
                    end
                end
            end
            LOCKED: begin
                if ((accept & ~intol) | x_sat) begin
                    state_nx = UNLOCKED;
                    good_nx  = '0;
                    err_nx   = 1'b1;
                end
            end
            default: state_nx = UNLOCKED;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= UNLOCKED;
            good  <= '0;
            x     <= '0;
            len   <= '0;
            y     <= '0;
            ls    <= 1'b0;
            vs    <= 1'b0;
            le    <= 1'b0;
            pix   <= 1'b0;
            pv    <= 1'b0;
        end else begin
            state <= state_nx;
            good  <= good_nx;
            ls    <= accept;
            vs    <= vs_evt;
            le    <= err_nx;
            pix   <= lum_r;
            pv    <= (state == LOCKED) & ~sync_r;
            if (accept) begin
                x   <= '0;
                len <= x_sat ? X_MAX : x_inc[X_WIDTH-1:0];
            end else if (!x_sat) begin
                x <= x + x_t'(1);
            end
            if (vs_evt)
                y <= '0;
            else if (accept)
                y <= y + y_t'(1);
        end
    end

    assign vid.line_start  = ls;
    assign vid.vsync_pulse = vs;
    assign vid.line_length = len;
    assign vid.pixel_x     = x;
    assign vid.line_y      = y;
    assign vid.pixel       = pix;
    assign vid.pixel_valid = pv;
    assign vid.locked      = (state == LOCKED);
    assign vid.lock_error  = le;

endmodule
